vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels; H_TOTAL = sum of the four horizontal parameters = 800.
REQ-005 SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, in lines; V_TOTAL = 525.
REQ-009 SHALL have parameter CLK_DIV, default 2: Clk cycles per pixel; legal values are 2 or greater.
REQ-010 SHALL have port Clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-011 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-012 SHALL have port pixel_clk, output, 1 bit: divided pixel clock for the DAC.
REQ-013 SHALL have port hs, output, 1 bit: horizontal sync, active low.
REQ-014 SHALL have port vs, output, 1 bit: vertical sync, active low.
REQ-015 SHALL have port blank_n, output, 1 bit: 1 = visible region, 0 = blanking.
REQ-016 SHALL have port sync, output, 1 bit: composite sync, tied to constant 0.
REQ-017 SHALL have port frame_start, output, 1 bit: one-Clk pulse at the start of each frame.
REQ-018 SHALL have ports DrawX and DrawY, output, 10 bits each: current horizontal and vertical pixel counts.

Function
REQ-019 SHALL keep a divider div_cnt counting 0..CLK_DIV-1 that wraps to 0; a pixel tick occurs on the Clk edge where div_cnt == CLK_DIV-1.
REQ-020 SHALL, on each tick, increment DrawX; at the tick where DrawX == H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
REQ-021 SHALL, when DrawX wraps and DrawY == V_TOTAL-1, wrap DrawY to 0 in the same edge; there is no state between line 524 and line 0.
REQ-022 SHALL hold DrawX and DrawY constant on non-tick edges.
REQ-023 SHALL drive hs = 0 exactly while H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751), and 1 otherwise.
REQ-024 SHALL drive vs = 0 exactly while V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491), and 1 otherwise.
REQ-025 SHALL drive blank_n = 1 exactly while DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-026 SHALL register hs, vs and blank_n from the next counter values, so they are coherent with DrawX/DrawY in every Clk cycle: zero relative latency, no combinational output paths.
REQ-027 SHALL register pixel_clk as 1 when div_cnt >= CLK_DIV/2 (integer division), else 0; with CLK_DIV = 2 this gives a 50% duty cycle, with the rising edge mid-pixel.
REQ-028 SHALL pulse frame_start high for exactly one Clk cycle, namely the cycle in which DrawX and DrawY have just become (0,0) via wrap; it stays 0 at all other times, including the cycle after reset.
REQ-029 SHALL give Reset priority over tick; Reset asserted mid-line or mid-frame abandons the frame with no partial pulses.

Reset
REQ-030 SHALL, on a Clk edge with Reset = 1, set div_cnt = 0, DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank_n = 1, pixel_clk = 0 and frame_start = 0.
REQ-031 SHALL resume counting on the first edge with Reset = 0, with the first tick occurring CLK_DIV edges after reset release.

Verification
REQ-032 SHALL cover reset release (CLK_DIV = 2): DrawX steps 0->1 on the 2nd edge after release, and pixel_clk is 0,1,0,1 on the successive cycles.
REQ-033 SHALL cover horizontal timing: hs falls when DrawX becomes 656 (Clk 1312 after release) and rises at 752; blank_n falls at DrawX = 640; the line period is 1600 Clk.
REQ-034 SHALL cover line wrap: DrawX 799->0 with DrawY 0->1 on the same edge; blank_n = 1 again at (0,1).
REQ-035 SHALL cover vertical timing: vs is low for exactly 2 lines (DrawY 490..491, 3200 Clk); blank_n stays 0 for all of DrawY 480..524.
REQ-036 SHALL cover frame wrap: (799,524)->(0,0) occurs at Clk 840000 after release, with frame_start high for exactly that one cycle; the next pulse comes 840000 Clk later.
REQ-037 SHALL cover reset mid-frame: Reset asserted at (300,200) forces (0,0), hs = vs = 1 and frame_start = 0 on the next edge, and counting restarts per REQ-031.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel/line counters with registered sync, blank and frame strobe
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank_n,
  output logic       sync,
  output logic       frame_start,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic          tick;
  logic          frame_wrap;

  // Composite sync is unused by the DAC path.
  assign sync = 1'b0;

  // Next divider and counter values; outputs are registered from these so they line up with DrawX/DrawY.
  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    div_nxt    = tick ? '0 : div_cnt + DW'(1);
    x_nxt      = DrawX;
    y_nxt      = DrawY;
    frame_wrap = 1'b0;
    if (tick) begin
      if (DrawX == H_LAST) begin
        x_nxt = '0;
        if (DrawY == V_LAST) begin
          y_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          y_nxt = DrawY + 10'd1;
        end
      end else begin
        x_nxt = DrawX + 10'd1;
      end
    end
  end

  // Counter and output registers; reset wins over any pending tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt     <= '0;
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank_n     <= 1'b1;
      pixel_clk   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      hs          <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
      vs          <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
      blank_n     <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      pixel_clk   <= (div_nxt >= DIV_HALF);
      frame_start <= frame_wrap;
    end
  end

endmodule
